// File: rtl/mini_core_dmem_rsp_pkg.sv
// mini_core_dmem_rsp_pkg: request bundle, responder FSM states and latency counter width for the D_MEM responder.
package mini_core_dmem_rsp_pkg;
  localparam int DMEM_CNT_W = 3;
  typedef struct packed {
    logic [31:0] WrData;
    logic [31:0] Address;
    logic [3:0]  ByteEn;
    logic        WrEn;
    logic        RdEn;
  } t_core2dmem_req;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} t_dmem_rsp_state;
endpackage

// File: rtl/mini_core_dmem_rsp_if.sv
// mini_core_dmem_rsp_if: Q103H request / Q104H response bus between the core (master) and D_MEM (slave).
interface mini_core_dmem_rsp_if;
  logic [31:0] DMemWrDataQ103H;
  logic [31:0] DMemAddressQ103H;
  logic [3:0]  DMemByteEnQ103H;
  logic        DMemWrEnQ103H;
  logic        DMemRdEnQ103H;
  logic        DMemReady;
  logic [31:0] DMemRdRspQ104H;
  logic        DMemRdRspValid;
  logic        DMemAddrErr;
  modport master (
    output DMemWrDataQ103H, DMemAddressQ103H, DMemByteEnQ103H, DMemWrEnQ103H, DMemRdEnQ103H,
    input  DMemReady, DMemRdRspQ104H, DMemRdRspValid, DMemAddrErr
  );
  modport slave (
    input  DMemWrDataQ103H, DMemAddressQ103H, DMemByteEnQ103H, DMemWrEnQ103H, DMemRdEnQ103H,
    output DMemReady, DMemRdRspQ104H, DMemRdRspValid, DMemAddrErr
  );
endinterface

// File: rtl/mini_core_dmem_array.sv
// mini_core_dmem_array: word storage with per-byte-lane sync write and async read; never reset.
module mini_core_dmem_array #(
  parameter int WORDS = 4096,
  localparam int IW = $clog2(WORDS)
) (
  input  logic          Clock,
  input  logic          wrEn,
  input  logic [3:0]    byteEn,
  input  logic [IW-1:0] wrIdx,
  input  logic [31:0]   wrData,
  input  logic [IW-1:0] rdIdx,
  output logic [31:0]   rdData
);
  logic [3:0][7:0] mem [WORDS];
  always_ff @(posedge Clock)
    for (int i = 0; i < 4; i++)
      if (wrEn && byteEn[i]) mem[wrIdx][i] <= wrData[8*i +: 8];
  assign rdData = mem[rdIdx];
endmodule

// File: rtl/mini_core_dmem_rsp.sv
// mini_core_dmem_rsp: D_MEM responder; commits stores at accept, returns loads after RD_LAT cycles,
// stalls via DMemReady while a multi-cycle load is in flight and flags out-of-range/illegal requests.
module mini_core_dmem_rsp
  import mini_core_dmem_rsp_pkg::*;
#(
  parameter int          DMEM_SIZE = 16384,
  parameter logic [31:0] DMEM_BASE = 32'h0001_0000,
  parameter int          RD_LAT    = 1
) (
  input logic Clock,
  input logic Rst,
  mini_core_dmem_rsp_if.slave dmem
);
  localparam int AW = $clog2(DMEM_SIZE);
  t_core2dmem_req req;
  t_dmem_rsp_state state, nextState;
  logic [DMEM_CNT_W-1:0] cnt, nextCnt;
  logic [31:0] offset, arrRd;
  logic [AW-3:0] curIdx, reqIdx, rdIdx;
  logic curInRange, reqInRange, rspInRange, wrAccept, rdAccept, rspLoad;
  assign req = '{WrData: dmem.DMemWrDataQ103H, Address: dmem.DMemAddressQ103H,
                 ByteEn: dmem.DMemByteEnQ103H, WrEn: dmem.DMemWrEnQ103H, RdEn: dmem.DMemRdEnQ103H};
  assign offset = req.Address - DMEM_BASE;
  assign curInRange = req.Address >= DMEM_BASE && offset < 32'(DMEM_SIZE);
  assign curIdx = offset[AW-1:2];
  // Single-cycle loads use the live request; longer ones use the copy captured at accept.
  assign rdIdx = RD_LAT == 1 ? curIdx : reqIdx;
  assign rspInRange = RD_LAT == 1 ? curInRange : reqInRange;
  always_ff @(posedge Clock or negedge Rst)
    if (!Rst) begin
      state <= DMEM_IDLE;
      cnt <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
    end
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    case (state)
      DMEM_IDLE: if (rdAccept && RD_LAT > 1) begin
        nextState = DMEM_WAIT;
        nextCnt = DMEM_CNT_W'(RD_LAT - 1);
      end
      DMEM_WAIT: begin
        nextState = cnt == DMEM_CNT_W'(1) ? DMEM_RESP : DMEM_WAIT;
        nextCnt = cnt - DMEM_CNT_W'(1);
      end
      default: nextState = DMEM_IDLE;
    endcase
  end
  always_comb begin
    dmem.DMemReady = state == DMEM_IDLE;
    wrAccept = req.WrEn && state == DMEM_IDLE;
    rdAccept = req.RdEn && !req.WrEn && state == DMEM_IDLE;
    rspLoad = RD_LAT == 1 ? rdAccept : state == DMEM_WAIT && cnt == DMEM_CNT_W'(1);
  end
  always_ff @(posedge Clock or negedge Rst)
    if (!Rst) begin
      reqIdx <= '0;
      reqInRange <= 1'b0;
      dmem.DMemRdRspValid <= 1'b0;
      dmem.DMemAddrErr <= 1'b0;
      dmem.DMemRdRspQ104H <= '0;
    end else begin
      if (rdAccept) begin
        reqIdx <= curIdx;
        reqInRange <= curInRange;
      end
      dmem.DMemRdRspValid <= rspLoad;
      dmem.DMemAddrErr <= (rspLoad && !rspInRange) || (wrAccept && (!curInRange || req.RdEn));
      if (rspLoad) dmem.DMemRdRspQ104H <= rspInRange ? arrRd : '0;
    end
  mini_core_dmem_array #(.WORDS(DMEM_SIZE / 4)) uArray (
    .Clock (Clock),
    .wrEn  (wrAccept && curInRange),
    .byteEn(req.ByteEn),
    .wrIdx (curIdx),
    .wrData(req.WrData),
    .rdIdx (rdIdx),
    .rdData(arrRd)
  );
endmodule

// File: tb/tb_mini_core_dmem_rsp.sv
// tb_mini_core_dmem_rsp: directed vector tables plus random traffic against a cycle-level memory model,
// on two responders (RD_LAT=1 and RD_LAT=4) sharing one clock and reset.
module tb_mini_core_dmem_rsp;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int SIZE = 16384;
  typedef struct { logic [31:0] wd, addr; logic [3:0] be; logic we, re; } req_t;
  typedef struct { req_t req; logic ready, valid, err; logic [31:0] data; } vec_t;
  logic Clock = 0, Rst = 0;
  int total = 0, bad = 0;
  vec_t tbl[$];
  logic [31:0] mdl [2][SIZE/4];
  int rdDue[2], wrErrCyc[2], busyUntil[2];
  int lat[2] = '{1, 4};
  logic [31:0] rdData[2], lastData[2];
  logic rdErr[2];
  mini_core_dmem_rsp_if bus1();
  mini_core_dmem_rsp_if bus4();
  mini_core_dmem_rsp #(.RD_LAT(1)) u1 (.Clock(Clock), .Rst(Rst), .dmem(bus1));
  mini_core_dmem_rsp #(.RD_LAT(4)) u4 (.Clock(Clock), .Rst(Rst), .dmem(bus4));
  always #5 Clock = ~Clock;

  function automatic req_t mk(logic we, logic re, logic [31:0] addr, logic [31:0] wd, logic [3:0] be);
    return '{wd: wd, addr: addr, be: be, we: we, re: re};
  endfunction
  function automatic vec_t v(req_t r, logic rdy, logic vl, logic er, logic [31:0] dt);
    return '{req: r, ready: rdy, valid: vl, err: er, data: dt};
  endfunction
  task automatic drive(int d, req_t r);
    if (d == 0) begin
      bus1.DMemWrDataQ103H = r.wd; bus1.DMemAddressQ103H = r.addr; bus1.DMemByteEnQ103H = r.be;
      bus1.DMemWrEnQ103H = r.we; bus1.DMemRdEnQ103H = r.re;
    end else begin
      bus4.DMemWrDataQ103H = r.wd; bus4.DMemAddressQ103H = r.addr; bus4.DMemByteEnQ103H = r.be;
      bus4.DMemWrEnQ103H = r.we; bus4.DMemRdEnQ103H = r.re;
    end
  endtask
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic checkAll(string tag, int d, logic r, logic vl, logic e, logic [31:0] dt);
    logic gr, gv, ge;
    logic [31:0] gd;
    if (d == 0) begin
      gr = bus1.DMemReady; gv = bus1.DMemRdRspValid; ge = bus1.DMemAddrErr; gd = bus1.DMemRdRspQ104H;
    end else begin
      gr = bus4.DMemReady; gv = bus4.DMemRdRspValid; ge = bus4.DMemAddrErr; gd = bus4.DMemRdRspQ104H;
    end
    check({tag, " ready"}, 32'(gr), 32'(r));
    check({tag, " valid"}, 32'(gv), 32'(vl));
    check({tag, " err"}, 32'(ge), 32'(e));
    check({tag, " data"}, gd, dt);
  endtask
  task automatic runTable(string name, int d);
    foreach (tbl[i]) begin
      @(negedge Clock);
      checkAll($sformatf("%s row%0d dut%0d", name, i, d), d, tbl[i].ready, tbl[i].valid, tbl[i].err, tbl[i].data);
      drive(d, tbl[i].req);
    end
    tbl.delete();
  endtask

  initial begin
    req_t idle, r;
    idle = mk(0, 0, 0, 0, 0);
    drive(0, idle);
    drive(1, idle);
    repeat (3) @(negedge Clock);
    checkAll("in reset dut0", 0, 1, 0, 0, 0);
    checkAll("in reset dut1", 1, 1, 0, 0, 0);
    Rst = 1;
    // Single-cycle latency: write/read, byte lanes, range edges, illegal and empty-enable stores.
    tbl.push_back(v(mk(1, 0, BASE, 32'hDEADBEEF, 4'hF), 1, 0, 0, 0));
    tbl.push_back(v(mk(0, 1, BASE, 0, 0), 1, 0, 0, 0));
    tbl.push_back(v(mk(1, 0, BASE, 32'h000000AA, 4'b0001), 1, 1, 0, 32'hDEADBEEF));
    tbl.push_back(v(mk(0, 1, BASE + 3, 0, 0), 1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(v(mk(0, 1, 32'h0000_0FFC, 0, 0), 1, 1, 0, 32'hDEADBEAA));
    tbl.push_back(v(mk(1, 0, BASE + SIZE, 32'h11223344, 4'hF), 1, 1, 1, 0));
    tbl.push_back(v(mk(0, 1, BASE, 0, 0), 1, 0, 1, 0));
    tbl.push_back(v(mk(1, 0, BASE + SIZE - 4, 32'hCAFEF00D, 4'hF), 1, 1, 0, 32'hDEADBEAA));
    tbl.push_back(v(mk(0, 1, BASE + SIZE - 4, 0, 0), 1, 0, 0, 32'hDEADBEAA));
    tbl.push_back(v(mk(1, 1, BASE + 8, 32'h12345678, 4'hF), 1, 1, 0, 32'hCAFEF00D));
    tbl.push_back(v(mk(1, 0, BASE + 8, 32'hFFFFFFFF, 4'h0), 1, 0, 1, 32'hCAFEF00D));
    tbl.push_back(v(mk(0, 1, BASE + 8, 0, 0), 1, 0, 0, 32'hCAFEF00D));
    tbl.push_back(v(idle, 1, 1, 0, 32'h12345678));
    tbl.push_back(v(idle, 1, 0, 0, 32'h12345678));
    runTable("lat1", 0);
    // Four-cycle latency: stall window, held-off request with a changed address, out-of-range load.
    tbl.push_back(v(mk(1, 0, BASE + 4, 32'h0BADC0DE, 4'hF), 1, 0, 0, 0));
    tbl.push_back(v(mk(0, 1, BASE + 4, 0, 0), 1, 0, 0, 0));
    repeat (3) tbl.push_back(v(mk(0, 1, 0, 0, 0), 0, 0, 0, 0));
    tbl.push_back(v(mk(0, 1, 0, 0, 0), 0, 1, 0, 32'h0BADC0DE));
    tbl.push_back(v(mk(0, 1, 0, 0, 0), 1, 0, 0, 32'h0BADC0DE));
    repeat (3) tbl.push_back(v(idle, 0, 0, 0, 32'h0BADC0DE));
    tbl.push_back(v(idle, 0, 1, 1, 0));
    tbl.push_back(v(idle, 1, 0, 0, 0));
    runTable("lat4", 1);
    // Reset while a load is waiting.
    @(negedge Clock);
    drive(1, mk(0, 1, BASE + 4, 0, 0));
    @(negedge Clock);
    drive(1, idle);
    checkAll("pre-reset wait dut1", 1, 0, 0, 0, 0);
    #2 Rst = 0;
    #1;
    checkAll("mid-read reset dut0", 0, 1, 0, 0, 0);
    checkAll("mid-read reset dut1", 1, 1, 0, 0, 0);
    @(negedge Clock);
    Rst = 1;
    repeat (6) begin
      @(negedge Clock);
      checkAll("after reset dut1", 1, 1, 0, 0, 0);
    end
    tbl.push_back(v(mk(0, 1, BASE + 4, 0, 0), 1, 0, 0, 0));
    repeat (3) tbl.push_back(v(idle, 0, 0, 0, 0));
    tbl.push_back(v(idle, 0, 1, 0, 32'h0BADC0DE));
    tbl.push_back(v(idle, 1, 0, 0, 32'h0BADC0DE));
    runTable("preserved", 1);
    // Random traffic against the cycle model.
    @(negedge Clock);
    Rst = 0;
    @(negedge Clock);
    Rst = 1;
    for (int d = 0; d < 2; d++) begin
      rdDue[d] = -1; wrErrCyc[d] = -1; busyUntil[d] = 0; lastData[d] = 0; rdErr[d] = 0; rdData[d] = 0;
    end
    for (int c = 0; c < 500; c++) begin
      @(negedge Clock);
      for (int d = 0; d < 2; d++) begin
        logic ev, ee, inr;
        logic [31:0] ed;
        int k, sel, idx;
        ev = rdDue[d] == c;
        ee = (ev && rdErr[d]) || wrErrCyc[d] == c;
        ed = ev ? rdData[d] : lastData[d];
        lastData[d] = ed;
        checkAll($sformatf("rand c%0d dut%0d", c, d), d, c >= busyUntil[d], ev, ee, ed);
        k = $urandom_range(0, 9);
        sel = $urandom_range(0, 9);
        r.addr = k < 8 ? BASE + 32'(4 * k) + 32'($urandom_range(0, 3))
               : k == 8 ? BASE + SIZE + 32'(4 * $urandom_range(0, 3)) : BASE - 4;
        r.wd = $urandom;
        r.be = 4'($urandom_range(0, 15));
        r.we = sel < 4 || sel == 8;
        r.re = (sel >= 4 && sel < 8) || sel == 8;
        if (c < 8) r = mk(1, 0, BASE + 32'(4 * c), $urandom, 4'hF);
        drive(d, r);
        inr = r.addr >= BASE && r.addr < BASE + SIZE;
        if (c >= busyUntil[d] && r.we) begin
          if (inr) begin
            idx = int'((r.addr - BASE) >> 2);
            for (int i = 0; i < 4; i++) if (r.be[i]) mdl[d][idx][8*i +: 8] = r.wd[8*i +: 8];
          end
          if (!inr || r.re) wrErrCyc[d] = c + 1;
        end else if (c >= busyUntil[d] && r.re) begin
          rdDue[d] = c + lat[d];
          rdErr[d] = !inr;
          rdData[d] = 0;
          if (inr) rdData[d] = mdl[d][int'((r.addr - BASE) >> 2)];
          busyUntil[d] = lat[d] > 1 ? c + lat[d] + 1 : c + 1;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
